// File: rtl/mdio_master_param_if.sv
// System-side request/response and MDIO pad signals of the MDIO management master.
// The master modport belongs to the block; the slave modport is the request/pad side.
interface mdio_master_param_if;
  logic        MDIO_START;
  logic [31:0] T_DATA;
  logic        MDIO_IN;
  logic [15:0] RD_DATA;
  logic        DATA_RDY;
  logic        DONE;
  logic        BUSY;
  logic        MDC;
  logic        MDIO_OE;
  logic        MDIO_OUT;

  modport master (
    input  MDIO_START, T_DATA, MDIO_IN,
    output RD_DATA, DATA_RDY, DONE, BUSY, MDC, MDIO_OE, MDIO_OUT
  );

  modport slave (
    output MDIO_START, T_DATA, MDIO_IN,
    input  RD_DATA, DATA_RDY, DONE, BUSY, MDC, MDIO_OE, MDIO_OUT
  );
endinterface

// File: rtl/mdio_master_param.sv
// MDIO management master: preamble plus one 32-bit frame per request, with a
// programmable MDC divider and read-data capture after turnaround.
//
// state    | meaning
// IDLE     | bus released, waiting for MDIO_START
// PREAMBLE | driving PREAMBLE_LEN leading ones
// FRAME    | shifting the 32-bit frame; on reads OE drops from the first TA bit
module mdio_master_param #(
  parameter int CLK_DIV      = 2,
  parameter int PREAMBLE_LEN = 32,
  parameter int CNT_W        = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  mdio_master_param_if.master bus
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, FRAME} state_t;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_ONE  = CNT_W'(1);
  localparam logic [5:0]       PRE_LAST = (PREAMBLE_LEN > 0) ? 6'(PREAMBLE_LEN - 1) : 6'd0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [31:0]      shreg_q, shreg_d;
  logic             is_read_q, is_read_d;
  logic [15:0]      rd_shift_q, rd_shift_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic             mdc_q, mdc_d;
  logic             mdio_oe_q, mdio_oe_d;
  logic             mdio_out_q, mdio_out_d;
  logic             done_q, done_d;
  logic             data_rdy_q, data_rdy_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      is_read_q  <= 1'b0;
      rd_shift_q <= '0;
      rd_data_q  <= '0;
      mdc_q      <= 1'b0;
      mdio_oe_q  <= 1'b0;
      mdio_out_q <= 1'b0;
      done_q     <= 1'b0;
      data_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      is_read_q  <= is_read_d;
      rd_shift_q <= rd_shift_d;
      rd_data_q  <= rd_data_d;
      mdc_q      <= mdc_d;
      mdio_oe_q  <= mdio_oe_d;
      mdio_out_q <= mdio_out_d;
      done_q     <= done_d;
      data_rdy_q <= data_rdy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    is_read_d  = is_read_q;
    rd_shift_d = rd_shift_q;
    rd_data_d  = rd_data_q;
    mdc_d      = mdc_q;
    mdio_oe_d  = mdio_oe_q;
    mdio_out_d = mdio_out_q;
    done_d     = 1'b0;
    data_rdy_d = 1'b0;

    case (state_q)
      IDLE: begin
        // The DONE cycle still reads as IDLE, but a start there is dropped.
        if (bus.MDIO_START && !done_q) begin
          shreg_d    = bus.T_DATA;
          is_read_d  = bus.T_DATA[29];
          div_cnt_d  = DIV_LAST;
          rd_shift_d = '0;
          mdc_d      = 1'b0;
          mdio_oe_d  = 1'b1;
          if (PREAMBLE_LEN == 0) begin
            state_d    = FRAME;
            bit_cnt_d  = 6'd31;
            mdio_out_d = bus.T_DATA[31];
          end else begin
            state_d    = PREAMBLE;
            bit_cnt_d  = PRE_LAST;
            mdio_out_d = 1'b1;
          end
        end
      end
      default: begin
        if (div_cnt_q != '0) begin
          div_cnt_d = div_cnt_q - DIV_ONE;
        end else begin
          div_cnt_d = DIV_LAST;
          mdc_d     = !mdc_q;
          if (!mdc_q) begin
            // MDC rising: bit_cnt 15..0 are frame bits 16..31, the read data.
            if (state_q == FRAME && is_read_q && bit_cnt_q <= 6'd15)
              rd_shift_d = {rd_shift_q[14:0], bus.MDIO_IN};
          end else if (state_q == PREAMBLE) begin
            if (bit_cnt_q == 6'd0) begin
              state_d    = FRAME;
              bit_cnt_d  = 6'd31;
              mdio_out_d = shreg_q[31];
            end else begin
              bit_cnt_d  = bit_cnt_q - 6'd1;
            end
          end else if (bit_cnt_q == 6'd0) begin
            state_d    = IDLE;
            div_cnt_d  = '0;
            mdc_d      = 1'b0;
            mdio_oe_d  = 1'b0;
            mdio_out_d = 1'b0;
            done_d     = 1'b1;
            if (is_read_q) begin
              data_rdy_d = 1'b1;
              rd_data_d  = rd_shift_q;
            end
          end else begin
            // Next bit has bit_cnt <= 17 (frame bit >= 14): release on reads.
            bit_cnt_d  = bit_cnt_q - 6'd1;
            shreg_d    = {shreg_q[30:0], 1'b0};
            mdio_oe_d  = !(is_read_q && bit_cnt_q <= 6'd18);
            mdio_out_d = mdio_oe_d ? shreg_q[30] : 1'b0;
          end
        end
      end
    endcase
  end

  always_comb begin
    bus.RD_DATA  = rd_data_q;
    bus.DATA_RDY = data_rdy_q;
    bus.DONE     = done_q;
    bus.BUSY     = (state_q != IDLE);
    bus.MDC      = mdc_q;
    bus.MDIO_OE  = mdio_oe_q;
    bus.MDIO_OUT = mdio_out_q;
  end

endmodule

// File: tb/tb_mdio_master_param.sv
// Bench for mdio_master_param: default instance plus a CLK_DIV=1, PREAMBLE_LEN=0 instance,
// cycle-by-cycle waveform model and a DONE/RD_DATA scoreboard.
module tb_mdio_master_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  mdio_master_param_if ifa ();
  mdio_master_param_if ifb ();

  mdio_master_param dut_a (.CLK(clk), .RESET(rst), .bus(ifa));
  mdio_master_param #(.CLK_DIV(1), .PREAMBLE_LEN(0)) dut_b (.CLK(clk), .RESET(rst), .bus(ifb));

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int          due;
    logic [15:0] rd;
    logic        rdy;
  } sb_t;

  sb_t q_a[$];
  sb_t q_b[$];
  sb_t ea, eb;

  // Scoreboard: every DONE pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (ifa.DONE === 1'b1) begin
      if (q_a.size() == 0) chk("done_without_request_a", ifa.DONE, 0);
      else begin
        ea = q_a.pop_front();
        chk("done_cycle_a", cyc, ea.due);
        chk("rd_data_a", ifa.RD_DATA, ea.rd);
        chk("data_rdy_a", ifa.DATA_RDY, ea.rdy);
      end
    end else if (ifa.DATA_RDY === 1'b1) chk("data_rdy_without_done_a", ifa.DATA_RDY, 0);
    if (ifb.DONE === 1'b1) begin
      if (q_b.size() == 0) chk("done_without_request_b", ifb.DONE, 0);
      else begin
        eb = q_b.pop_front();
        chk("done_cycle_b", cyc, eb.due);
        chk("rd_data_b", ifb.RD_DATA, eb.rd);
        chk("data_rdy_b", ifb.DATA_RDY, eb.rdy);
      end
    end else if (ifb.DATA_RDY === 1'b1) chk("data_rdy_without_done_b", ifb.DATA_RDY, 0);
  end

  typedef struct {
    bit          sel;
    logic [31:0] tdata;
    logic [15:0] resp;
    logic [15:0] exp_rd;
    bit          noise;
  } vec_t;

  vec_t vecs[6];
  logic [15:0] hold_a = 16'h0;
  logic [15:0] hold_b = 16'h0;

  task automatic drive(input bit sel, input logic start, input logic [31:0] td, input logic din);
    if (sel) begin
      ifb.MDIO_START = start; ifb.T_DATA = td; ifb.MDIO_IN = din;
    end else begin
      ifa.MDIO_START = start; ifa.T_DATA = td; ifa.MDIO_IN = din;
    end
  endtask

  function automatic logic [19:0] snap(input bit sel);
    if (sel) return {ifb.BUSY, ifb.MDC, ifb.MDIO_OE, ifb.MDIO_OUT, ifb.RD_DATA};
    return {ifa.BUSY, ifa.MDC, ifa.MDIO_OE, ifa.MDIO_OUT, ifa.RD_DATA};
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after DONE.
  task automatic run_frame(input vec_t v);
    int p    = v.sel ? 0 : 32;
    int d    = v.sel ? 1 : 2;
    int last = 2 * (p + 32) * d;
    bit rd   = v.tdata[29];
    logic [15:0] hold = v.sel ? hold_b : hold_a;
    sb_t e;
    int k, f;
    logic st, din, e_mdc, e_oe, e_out, e_busy;
    logic [15:0] e_rd;
    e.due = cyc + 1 + last;
    e.rd  = v.exp_rd;
    e.rdy = rd;
    if (v.sel) q_b.push_back(e); else q_a.push_back(e);
    drive(v.sel, 1'b1, v.tdata, 1'b0);
    @(negedge clk);
    for (int c = 0; c <= last; c++) begin
      if (c > 0) @(negedge clk);
      k   = c / (2 * d);
      f   = k - p;
      din = (c < last && f >= 16) ? v.resp[31 - f] : 1'b0;
      st  = v.noise && (c == 10 || c == 200 || c == last);
      drive(v.sel, st, ~v.tdata, din);
      if (c == last) begin
        e_busy = 0; e_mdc = 0; e_oe = 0; e_out = 0; e_rd = v.exp_rd;
      end else begin
        e_busy = 1;
        e_mdc  = ((c / d) % 2) == 1;
        e_rd   = hold;
        if (f < 0) begin
          e_oe = 1; e_out = 1;
        end else begin
          e_oe  = !(rd && f >= 14);
          e_out = e_oe ? v.tdata[31 - f] : 1'b0;
        end
      end
      chk(v.sel ? "wave_b" : "wave_a", snap(v.sel), {e_busy, e_mdc, e_oe, e_out, e_rd});
    end
    @(negedge clk);
    drive(v.sel, 1'b0, ~v.tdata, 1'b0);
    chk(v.sel ? "idle_after_done_b" : "idle_after_done_a", snap(v.sel), {4'b0000, v.exp_rd});
    if (v.sel) hold_b = v.exp_rd; else hold_a = v.exp_rd;
  endtask

  initial begin
    int bad;
    vecs[0] = '{1'b0, 32'h5196BEEF, 16'h0000, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 32'h61960000, 16'hA5C3, 16'hA5C3, 1'b0};
    vecs[2] = '{1'b1, 32'h00001234, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 32'h50A0C3C3, 16'h0000, 16'hA5C3, 1'b1};
    vecs[4] = '{1'b0, 32'h61960000, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[5] = '{1'b0, 32'h61960000, 16'h0001, 16'h0001, 1'b0};

    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_a", {snap(1'b0), ifa.DONE, ifa.DATA_RDY}, 22'h0);
    chk("reset_b", {snap(1'b1), ifb.DONE, ifb.DATA_RDY}, 22'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // Reset in the middle of a read: bus released on the next edge, no DONE.
    drive(1'b0, 1'b1, 32'h61960000, 1'b0);
    @(negedge clk);
    for (int c = 0; c <= 100; c++) begin
      if (c > 0) @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("after_mid_frame_reset", {snap(1'b0), ifa.DONE, ifa.DATA_RDY}, 22'h0);
    rst = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (ifa.BUSY || ifa.DONE || ifa.DATA_RDY || ifa.MDC || ifa.MDIO_OE) bad++;
    end
    chk("quiet_after_reset", bad, 0);
    chk("rd_data_after_reset", ifa.RD_DATA, 16'h0);
    chk("pending_sb_a", q_a.size(), 0);
    chk("pending_sb_b", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
